// File: rtl/audio_dac_i2s_tx.sv
// I2S master transmitter for the WM8731 DAC path: FIFO-buffered stereo PCM serialised on BCLK/DACLRCK/DACDAT.
// Frame load on enable and on each frame wrap; an empty FIFO at load transmits zeros and flags underflow.
module audio_dac_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_HALF  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            s_valid,
  input  logic [DATA_WIDTH-1:0]           s_left,
  input  logic [DATA_WIDTH-1:0]           s_right,
  output logic                            s_ready,
  output logic                            aud_bclk,
  output logic                            aud_daclrck,
  output logic                            aud_dacdat,
  output logic                            frame_start,
  output logic                            underflow,
  output logic [15:0]                     underflow_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int BIT_W = $clog2(2*SLOT_BITS);
  localparam int CNT_W = $clog2(BCLK_HALF);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2*SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_B    = BIT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BCLK_HALF - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state;
  logic [2*DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [LVL_W-1:0]          count;
  logic [CNT_W-1:0]          bclk_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]     shadow_l, shadow_r;

  logic fifo_full, fifo_empty, push, pop;
  logic start, bclk_tick, fall, wrap, load;
  logic [BIT_W-1:0] next_bit;
  logic [2*DATA_WIDTH-1:0] head;

  // Bit k of the slot: k=0 is the I2S one-bit delay, then MSB first, then zero padding.
  function automatic logic slot_bit(input logic [BIT_W-1:0] b,
                                    input logic [DATA_WIDTH-1:0] l,
                                    input logic [DATA_WIDTH-1:0] r);
    int k;
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] sh;
    k = int'(b);
    s = l;
    if (k >= SLOT_BITS) begin
      k = k - SLOT_BITS;
      s = r;
    end
    if (k >= 1 && k <= DATA_WIDTH) begin
      sh = s >> (DATA_WIDTH - k);
      return sh[0];
    end
    return 1'b0;
  endfunction

  assign fifo_full  = (count == LVL_FULL);
  assign fifo_empty = (count == '0);
  assign s_ready    = !fifo_full;
  assign fifo_level = count;
  assign push       = s_valid && !fifo_full;
  assign head       = mem[rd_ptr];

  always_comb begin
    start     = (state == IDLE) && enable;
    bclk_tick = (state == RUN) && enable && (bclk_cnt == CNT_LAST);
    fall      = bclk_tick && aud_bclk;
    wrap      = fall && (bit_cnt == BIT_LAST);
    load      = start || wrap;
    pop       = load && !fifo_empty;
    next_bit  = wrap ? '0 : bit_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_left, s_right};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bclk_cnt        <= '0;
      bit_cnt         <= '0;
      shadow_l        <= '0;
      shadow_r        <= '0;
      aud_bclk        <= 1'b0;
      aud_daclrck     <= 1'b0;
      aud_dacdat      <= 1'b0;
      frame_start     <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      frame_start <= load;
      underflow   <= load && fifo_empty;
      if (load && fifo_empty && underflow_count != 16'hFFFF)
        underflow_count <= underflow_count + 1'b1;

      // Loaded shadow registers are only consumed from k=1 onward, so loading at the wrap is safe.
      if (load) begin
        shadow_l <= pop ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        shadow_r <= pop ? head[DATA_WIDTH-1:0] : '0;
      end

      case (state)
        IDLE: begin
          bclk_cnt    <= '0;
          bit_cnt     <= '0;
          aud_bclk    <= 1'b0;
          aud_daclrck <= 1'b0;
          aud_dacdat  <= 1'b0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state       <= IDLE;
            bclk_cnt    <= '0;
            bit_cnt     <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
          end else if (bclk_cnt == CNT_LAST) begin
            bclk_cnt <= '0;
            aud_bclk <= !aud_bclk;
            if (aud_bclk) begin
              bit_cnt     <= next_bit;
              aud_daclrck <= (next_bit >= SLOT_B);
              aud_dacdat  <= slot_bit(next_bit, shadow_l, shadow_r);
            end
          end else begin
            bclk_cnt <= bclk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Directed bench for audio_dac_i2s_tx at default parameters (BCLK period 16 clk, frame 1024 clk).
module tb_audio_dac_i2s_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;
  logic        s_ready, aud_bclk, aud_daclrck, aud_dacdat;
  logic        frame_start, underflow;
  logic [15:0] underflow_count;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  audio_dac_i2s_tx dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_left(s_left), .s_right(s_right), .s_ready(s_ready),
    .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat),
    .frame_start(frame_start), .underflow(underflow),
    .underflow_count(underflow_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Collects the bit the codec samples at each BCLK rise: first 32 into l, next 32 into r.
  task automatic capture_frame(input int cycles, output logic [31:0] l, output logic [31:0] r);
    logic pb;
    int n;
    l = '0; r = '0; n = 0; pb = aud_bclk;
    for (int t = 0; t < cycles; t++) begin
      step();
      if (!pb && aud_bclk) begin
        if (n < 32) l = {l[30:0], aud_dacdat};
        else        r = {r[30:0], aud_dacdat};
        n++;
      end
      pb = aud_bclk;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({aud_bclk, aud_daclrck, aud_dacdat} !== 3'b000) begin errors++; $display("FAIL reset_serial got %b want 000", {aud_bclk, aud_daclrck, aud_dacdat}); end
    checks++; if ({frame_start, underflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {frame_start, underflow}); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", s_ready); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL reset_ucount got %0d want 0", underflow_count); end
  endtask

  task automatic test_serial_timing();
    logic [31:0] l, r;
    logic pb, pl, pd, fall, rise, fs_seen;
    int n, falls, lr_falls, first_rise, last_rise, bad_period, bad_change, lr_bad, fs_bad;
    s_valid = 1'b1; s_left = 16'hA5C3; s_right = 16'h8001;
    step();
    s_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL push_idle_level got %0d want 1", fifo_level); end
    enable = 1'b1;
    step();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL enable_frame_start got %b want 1", frame_start); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL enable_pop_level got %0d want 0", fifo_level); end
    l = '0; r = '0; n = 0; falls = 0; lr_falls = -1; first_rise = -1; last_rise = 0;
    bad_period = 0; bad_change = 0; lr_bad = 0; fs_bad = 0; fs_seen = 1'b0;
    pb = aud_bclk; pl = aud_daclrck; pd = aud_dacdat;
    for (int t = 1; t <= 1024; t++) begin
      step();
      fall = pb && !aud_bclk;
      rise = !pb && aud_bclk;
      if (fall) falls++;
      if (rise) begin
        if (first_rise < 0) first_rise = t;
        else if (t - last_rise != 16) bad_period++;
        last_rise = t;
        if (n < 32) l = {l[30:0], aud_dacdat};
        else        r = {r[30:0], aud_dacdat};
        if (aud_daclrck !== (n >= 32)) lr_bad++;
        n++;
      end
      if ((aud_daclrck !== pl || aud_dacdat !== pd) && !fall) bad_change++;
      if (!pl && aud_daclrck) lr_falls = falls;
      if (frame_start) begin
        if (t != 1024) fs_bad++;
        else fs_seen = 1'b1;
      end
      pb = aud_bclk; pl = aud_daclrck; pd = aud_dacdat;
    end
    checks++; if (l !== {1'b0, 16'hA5C3, 15'd0}) begin errors++; $display("FAIL left_slot got %h want %h", l, {1'b0, 16'hA5C3, 15'd0}); end
    checks++; if (r !== {1'b0, 16'h8001, 15'd0}) begin errors++; $display("FAIL right_slot got %h want %h", r, {1'b0, 16'h8001, 15'd0}); end
    checks++; if (first_rise !== 8) begin errors++; $display("FAIL first_rise got %0d want 8", first_rise); end
    checks++; if (bad_period !== 0 || n !== 64) begin errors++; $display("FAIL bclk_period bad=%0d rises=%0d want 0/64", bad_period, n); end
    checks++; if (lr_falls !== 32) begin errors++; $display("FAIL lrck_rise_falls got %0d want 32", lr_falls); end
    checks++; if (lr_bad !== 0) begin errors++; $display("FAIL lrck_slot got %0d bad want 0", lr_bad); end
    checks++; if (bad_change !== 0) begin errors++; $display("FAIL change_off_fall got %0d want 0", bad_change); end
    checks++; if (fs_bad !== 0 || fs_seen !== 1'b1) begin errors++; $display("FAIL frame_period stray=%0d seen=%b want 0/1", fs_bad, fs_seen); end
    enable = 1'b0;
    step();
    checks++; if ({aud_bclk, aud_daclrck, aud_dacdat} !== 3'b000) begin errors++; $display("FAIL disable_idle got %b want 000", {aud_bclk, aud_daclrck, aud_dacdat}); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_left = 16'h5500 + 16'(i); s_right = 16'h6600 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    enable = 1'b1;
    step();
    repeat (700) step();
    checks++; if (aud_daclrck !== 1'b1 || fifo_level !== 3'd1) begin errors++; $display("FAIL midframe_pre lrck=%b level=%0d want 1/1", aud_daclrck, fifo_level); end
    reset = 1'b1;
    step();
    checks++; if ({aud_bclk, aud_daclrck, aud_dacdat, frame_start} !== 4'b0000) begin errors++; $display("FAIL midreset_serial got %b want 0000", {aud_bclk, aud_daclrck, aud_dacdat, frame_start}); end
    checks++; if (fifo_level !== 3'd0 || s_ready !== 1'b1) begin errors++; $display("FAIL midreset_fifo level=%0d ready=%b want 0/1", fifo_level, s_ready); end
    checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL midreset_ucount got %0d want 0", underflow_count); end
    enable = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] l, r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_left = 16'h1100 + 16'(i); s_right = 16'h2100 + 16'(i);
      step();
    end
    checks++; if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin errors++; $display("FAIL full_state level=%0d ready=%b want 4/0", fifo_level, s_ready); end
    enable = 1'b1;
    step();
    checks++; if (fifo_level !== 3'd3 || s_ready !== 1'b1) begin errors++; $display("FAIL full_pop level=%0d ready=%b want 3/1", fifo_level, s_ready); end
    step();
    s_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL held_push level=%0d want 4", fifo_level); end
    capture_frame(1023, l, r);
    checks++; if (l !== {1'b0, 16'h1100, 15'd0} || r !== {1'b0, 16'h2100, 15'd0}) begin errors++; $display("FAIL fifo_order got %h/%h want %h/%h", l, r, {1'b0, 16'h1100, 15'd0}, {1'b0, 16'h2100, 15'd0}); end
    checks++; if (frame_start !== 1'b1 || fifo_level !== 3'd3) begin errors++; $display("FAIL second_load fs=%b level=%0d want 1/3", frame_start, fifo_level); end
  endtask

  task automatic test_disable_reenable();
    logic [31:0] l, r;
    int bad;
    repeat (300) step();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({aud_bclk, aud_daclrck, aud_dacdat, frame_start} !== 4'b0000) bad++;
    end
    checks++; if (bad !== 0 || fifo_level !== 3'd3) begin errors++; $display("FAIL disabled_idle bad=%0d level=%0d want 0/3", bad, fifo_level); end
    enable = 1'b1;
    step();
    checks++; if (frame_start !== 1'b1 || fifo_level !== 3'd2) begin errors++; $display("FAIL reenable_load fs=%b level=%0d want 1/2", frame_start, fifo_level); end
    capture_frame(1024, l, r);
    checks++; if (l !== {1'b0, 16'h1102, 15'd0} || r !== {1'b0, 16'h2102, 15'd0}) begin errors++; $display("FAIL reenable_data got %h/%h want %h/%h", l, r, {1'b0, 16'h1102, 15'd0}, {1'b0, 16'h2102, 15'd0}); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_underflow();
    int uf, ones;
    do_reset();
    enable = 1'b1;
    uf = 0; ones = 0;
    step();
    if (underflow) uf++;
    for (int t = 1; t <= 2048; t++) begin
      step();
      if (underflow) uf++;
      if (aud_dacdat) ones++;
    end
    checks++; if (uf !== 3) begin errors++; $display("FAIL underflow_pulses got %0d want 3", uf); end
    checks++; if (underflow_count !== 16'd3) begin errors++; $display("FAIL underflow_count got %0d want 3", underflow_count); end
    checks++; if (ones !== 0) begin errors++; $display("FAIL underflow_data got %0d ones want 0", ones); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_push_on_load();
    logic [31:0] l, r;
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_left = 16'h7777; s_right = 16'h7777;
    step();
    s_valid = 1'b0;
    checks++; if (underflow !== 1'b1 || fifo_level !== 3'd1 || underflow_count !== 16'd1) begin errors++; $display("FAIL push_on_load uf=%b level=%0d cnt=%0d want 1/1/1", underflow, fifo_level, underflow_count); end
    capture_frame(1024, l, r);
    checks++; if (l !== 32'd0 || r !== 32'd0) begin errors++; $display("FAIL push_on_load_data got %h/%h want 0/0", l, r); end
    checks++; if (frame_start !== 1'b1 || underflow !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL push_on_load_next fs=%b uf=%b level=%0d want 1/0/0", frame_start, underflow, fifo_level); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.underflow_count = 16'hFFFE;
    step();
    release dut.underflow_count;
    step();
    checks++; if (underflow_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h want fffe", underflow_count); end
    enable = 1'b1;
    step();
    checks++; if (underflow_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", underflow_count); end
    repeat (1024) step();
    checks++; if (underflow !== 1'b1 || underflow_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold uf=%b cnt=%h want 1/ffff", underflow, underflow_count); end
    enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_serial_timing();
    test_reset_midframe();
    test_back_to_back();
    test_disable_reenable();
    test_underflow();
    test_push_on_load();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
